// File: rtl/bmp180_pkg.sv
// Shared types and constants for the BMP180 sample collector: frame type codes,
// expected frame lengths, collector FSM states and small word-level helpers.
package bmp180_pkg;

  typedef enum logic [1:0] {
    FT_ID    = 2'd0,
    FT_CALIB = 2'd1,
    FT_TEMP  = 2'd2,
    FT_PRESS = 2'd3
  } frame_type_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    COMMIT  = 2'd2
  } state_e;

  localparam logic [4:0] LEN_ID    = 5'd1;
  localparam logic [4:0] LEN_CALIB = 5'd22;
  localparam logic [4:0] LEN_TEMP  = 5'd2;
  localparam logic [4:0] LEN_PRESS = 5'd3;

  localparam int CALIB_WORDS = 11;

  function automatic logic [4:0] frame_len(input frame_type_e t);
    case (t)
      FT_ID:    frame_len = LEN_ID;
      FT_CALIB: frame_len = LEN_CALIB;
      FT_TEMP:  frame_len = LEN_TEMP;
      FT_PRESS: frame_len = LEN_PRESS;
      default:  frame_len = LEN_ID;
    endcase
  endfunction

  // An erased or unprogrammed EEPROM word reads as all zeros or all ones.
  function automatic logic word_is_bad(input logic [15:0] w);
    word_is_bad = (w == 16'h0000) || (w == 16'hFFFF);
  endfunction

endpackage

// File: rtl/bmp180_calib_regfile.sv
// 11x16 calibration table (AC1..MD) written one byte lane at a time, with a
// combinational read port and a flag raised when any word looks erased.
module bmp180_calib_regfile
  import bmp180_pkg::*;
(
  input  logic        clk,
  input  logic        clear,
  input  logic        we,
  input  logic [3:0]  widx,
  input  logic        hi,
  input  logic [7:0]  wdata,
  input  logic [3:0]  raddr,
  output logic [15:0] rdata,
  output logic        bad
);

  logic [15:0] mem_r [CALIB_WORDS];

  // byte-lane write port with synchronous clear
  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < CALIB_WORDS; i++) begin
        mem_r[i] <= 16'h0000;
      end
    end else if (we && (widx < 4'(CALIB_WORDS))) begin
      if (hi) begin
        mem_r[widx][15:8] <= wdata;
      end else begin
        mem_r[widx][7:0] <= wdata;
      end
    end
  end

  // combinational read; indices past MD read as zero
  always_comb begin
    rdata = 16'h0000;
    if (raddr < 4'(CALIB_WORDS)) begin
      rdata = mem_r[raddr];
    end else begin
      rdata = 16'h0000;
    end
  end

  // OR-reduction of the per-word erased check
  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < CALIB_WORDS; i++) begin
      bad = bad | word_is_bad(mem_r[i]);
    end
  end

endmodule

// File: rtl/bmp180_sample_collector.sv
// Assembles the BMP180 controller's MSB-first byte stream into chip ID,
// calibration table, raw UT and raw UP, each exposed with valid/bad flags.
module bmp180_sample_collector
  import bmp180_pkg::*;
#(
  parameter int         OSS     = 0,
  parameter logic [7:0] CHIP_ID = 8'h55
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_start,
  input  logic [1:0]  frame_type,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  input  logic [3:0]  calib_addr,
  output logic [15:0] calib_data,
  output logic [7:0]  chip_id,
  output logic        id_valid,
  output logic        id_bad,
  output logic        calib_valid,
  output logic        calib_bad,
  output logic [15:0] ut,
  output logic        ut_valid,
  output logic [18:0] up,
  output logic        up_valid,
  output logic        frame_error,
  output logic        busy
);

  localparam int UP_SHIFT = 8 - OSS;

  state_e      state_r, state_s;
  frame_type_e type_r, cur_type_s;
  logic [4:0]  cnt_r, cur_cnt_s, cnt_s;
  logic [23:0] shift_r;
  logic [18:0] up_s;
  logic        take_s, err_s, commit_s, full_s;
  logic        rf_we_s, rf_bad_s;

  bmp180_calib_regfile u_regfile (
    .clk   (clk),
    .clear (reset),
    .we    (rf_we_s),
    .widx  (cur_cnt_s[4:1]),
    .hi    (~cur_cnt_s[0]),
    .wdata (byte_in),
    .raddr (calib_addr),
    .rdata (calib_data),
    .bad   (rf_bad_s)
  );

  assign up_s = 19'(shift_r >> UP_SHIFT);
  assign busy = (state_r != IDLE);

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // next state, byte acceptance and protocol-error decode
  always_comb begin
    state_s    = state_r;
    cur_type_s = type_r;
    cur_cnt_s  = cnt_r;
    take_s     = 1'b0;
    err_s      = 1'b0;
    commit_s   = 1'b0;
    full_s     = (cnt_r == frame_len(type_r));
    if (frame_start) begin
      // a coincident byte becomes byte 0 of the new frame
      cur_type_s = frame_type_e'(frame_type);
      cur_cnt_s  = 5'd0;
      take_s     = byte_valid;
      err_s      = (state_r != IDLE);
      state_s    = COLLECT;
    end else begin
      case (state_r)
        IDLE: begin
          err_s   = byte_valid;
          state_s = IDLE;
        end
        COLLECT: begin
          take_s  = byte_valid && !full_s;
          err_s   = byte_valid && full_s;
          state_s = full_s ? COMMIT : COLLECT;
        end
        COMMIT: begin
          err_s    = byte_valid;
          commit_s = 1'b1;
          state_s  = IDLE;
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
    cnt_s   = take_s ? (cur_cnt_s + 5'd1) : cur_cnt_s;
    rf_we_s = take_s && (cur_type_s == FT_CALIB);
  end

  // datapath registers and committed outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      type_r      <= FT_ID;
      cnt_r       <= 5'd0;
      shift_r     <= 24'h000000;
      chip_id     <= 8'h00;
      id_valid    <= 1'b0;
      id_bad      <= 1'b0;
      calib_valid <= 1'b0;
      calib_bad   <= 1'b0;
      ut          <= 16'h0000;
      ut_valid    <= 1'b0;
      up          <= 19'h00000;
      up_valid    <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      type_r      <= cur_type_s;
      cnt_r       <= cnt_s;
      frame_error <= err_s;
      ut_valid    <= commit_s && (type_r == FT_TEMP);
      up_valid    <= commit_s && (type_r == FT_PRESS);
      if (take_s) begin
        shift_r <= {shift_r[15:0], byte_in};
      end
      if (commit_s) begin
        case (type_r)
          FT_ID: begin
            chip_id  <= shift_r[7:0];
            id_valid <= 1'b1;
            id_bad   <= (shift_r[7:0] != CHIP_ID);
          end
          FT_CALIB: begin
            calib_valid <= 1'b1;
            calib_bad   <= rf_bad_s;
          end
          FT_TEMP:  ut <= shift_r[15:0];
          FT_PRESS: up <= up_s;
          default: begin
            ut <= ut;
          end
        endcase
      end else if (frame_start && (cur_type_s == FT_CALIB)) begin
        calib_valid <= 1'b0;
        calib_bad   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bmp180_sample_collector.sv
// Self-checking bench for bmp180_sample_collector: directed scenarios plus
// randomized frames compared against an arithmetic model of the frame contents.
module tb_bmp180_sample_collector;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_start = 1'b0;
  logic [1:0]  frame_type = 2'd0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic [3:0]  calib_addr = 4'd0;

  logic [15:0] calib_data, calib_data_3;
  logic [7:0]  chip_id, chip_id_3;
  logic        id_valid, id_valid_3, id_bad, id_bad_3;
  logic        calib_valid, calib_valid_3, calib_bad, calib_bad_3;
  logic [15:0] ut, ut_3;
  logic        ut_valid, ut_valid_3;
  logic [18:0] up, up_3;
  logic        up_valid, up_valid_3;
  logic        frame_error, frame_error_3, busy, busy_3;

  int errors = 0;
  int checks = 0;

  logic [7:0]  m_chip_id;
  logic        m_id_valid, m_id_bad, m_calib_valid, m_calib_bad;
  logic [15:0] m_calib [11];
  logic [15:0] m_ut;
  logic [18:0] m_up0, m_up3;
  logic [7:0]  fb [24];

  always #5 clk = ~clk;

  bmp180_sample_collector #(.OSS(0), .CHIP_ID(8'h55)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .frame_type(frame_type),
    .byte_in(byte_in), .byte_valid(byte_valid), .calib_addr(calib_addr),
    .calib_data(calib_data), .chip_id(chip_id), .id_valid(id_valid), .id_bad(id_bad),
    .calib_valid(calib_valid), .calib_bad(calib_bad), .ut(ut), .ut_valid(ut_valid),
    .up(up), .up_valid(up_valid), .frame_error(frame_error), .busy(busy)
  );

  bmp180_sample_collector #(.OSS(3), .CHIP_ID(8'h55)) dut3 (
    .clk(clk), .reset(reset), .frame_start(frame_start), .frame_type(frame_type),
    .byte_in(byte_in), .byte_valid(byte_valid), .calib_addr(calib_addr),
    .calib_data(calib_data_3), .chip_id(chip_id_3), .id_valid(id_valid_3), .id_bad(id_bad_3),
    .calib_valid(calib_valid_3), .calib_bad(calib_bad_3), .ut(ut_3), .ut_valid(ut_valid_3),
    .up(up_3), .up_valid(up_valid_3), .frame_error(frame_error_3), .busy(busy_3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_chip_id = 8'h00; m_id_valid = 1'b0; m_id_bad = 1'b0;
    m_calib_valid = 1'b0; m_calib_bad = 1'b0;
    m_ut = 16'h0000; m_up0 = 19'd0; m_up3 = 19'd0;
    for (int i = 0; i < 11; i++) m_calib[i] = 16'h0000;
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_valid = 1'b1; byte_in = b;
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [1:0] t, input int n);
    frame_start = 1'b1; frame_type = t;
    tick();
    frame_start = 1'b0;
    for (int i = 0; i < n; i++) send_byte(fb[i]);
  endtask

  task automatic load_datasheet_calib();
    m_calib = '{16'h0198, 16'hFFB8, 16'hC7D1, 16'h7FE5, 16'h7FF5, 16'h5A71,
                16'h182E, 16'h0004, 16'h8000, 16'hDDF9, 16'h0B34};
  endtask

  task automatic calib_to_bytes();
    for (int i = 0; i < 11; i++) begin
      fb[2*i]   = m_calib[i][15:8];
      fb[2*i+1] = m_calib[i][7:0];
    end
  endtask

  function automatic logic model_calib_bad();
    logic b = 1'b0;
    for (int i = 0; i < 11; i++) if (m_calib[i] == 16'h0000 || m_calib[i] == 16'hFFFF) b = 1'b1;
    return b;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    calib_addr = 4'd0; #1;
    checks++;
    if ({chip_id, id_valid, id_bad, calib_valid, calib_bad, ut, ut_valid, up, up_valid, frame_error, busy, calib_data} !== 76'd0)
      begin errors++; $display("FAIL reset_outputs: got chip_id=%0h ut=%0h up=%0h busy=%0b calib_data=%0h want all 0", chip_id, ut, up, busy, calib_data); end
    reset = 1'b0;
    model_clear();
    tick();
  endtask

  task automatic test_id();
    fb[0] = 8'h55;
    send_frame(2'd0, 1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL id_busy: got %0b want 1", busy); end
    tick();
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL id_valid_early: got %0b want 0", id_valid); end
    tick();
    checks++; if ({id_valid, id_bad, chip_id} !== {1'b1, 1'b0, 8'h55})
      begin errors++; $display("FAIL id_good: got v=%0b bad=%0b id=%0h want 1 0 55", id_valid, id_bad, chip_id); end
    fb[0] = 8'h54;
    send_frame(2'd0, 1);
    tick(); tick();
    checks++; if ({id_valid, id_bad, chip_id} !== {1'b1, 1'b1, 8'h54})
      begin errors++; $display("FAIL id_bad: got v=%0b bad=%0b id=%0h want 1 1 54", id_valid, id_bad, chip_id); end
    m_chip_id = 8'h54; m_id_valid = 1'b1; m_id_bad = 1'b1;
  endtask

  task automatic test_calib();
    logic [15:0] expv;
    load_datasheet_calib();
    calib_to_bytes();
    send_frame(2'd1, 22);
    tick();
    checks++; if (calib_valid !== 1'b0) begin errors++; $display("FAIL calib_valid_early: got %0b want 0", calib_valid); end
    tick();
    checks++; if ({calib_valid, calib_bad} !== 2'b10)
      begin errors++; $display("FAIL calib_flags: got v=%0b bad=%0b want 1 0", calib_valid, calib_bad); end
    for (int a = 0; a < 16; a++) begin
      calib_addr = 4'(a);
      @(negedge clk);
      expv = (a < 11) ? m_calib[a] : 16'h0000;
      checks++; if (calib_data !== expv) begin errors++; $display("FAIL calib_read[%0d]: got %0h want %0h", a, calib_data, expv); end
    end
    m_calib[3] = 16'hFFFF;
    calib_to_bytes();
    frame_start = 1'b1; frame_type = 2'd1;
    tick();
    frame_start = 1'b0;
    checks++; if (calib_valid !== 1'b0) begin errors++; $display("FAIL calib_start_clear: got %0b want 0", calib_valid); end
    for (int i = 0; i < 22; i++) send_byte(fb[i]);
    tick(); tick();
    checks++; if ({calib_valid, calib_bad} !== 2'b11)
      begin errors++; $display("FAIL calib_bad_word: got v=%0b bad=%0b want 1 1", calib_valid, calib_bad); end
    m_calib_valid = 1'b1; m_calib_bad = 1'b1;
  endtask

  task automatic test_temp_press();
    fb[0] = 8'h6C; fb[1] = 8'hFA;
    send_frame(2'd2, 2);
    tick();
    checks++; if (ut_valid !== 1'b0) begin errors++; $display("FAIL ut_valid_early: got %0b want 0", ut_valid); end
    tick();
    checks++; if ({ut_valid, ut} !== {1'b1, 16'd27898}) begin errors++; $display("FAIL ut_commit: got v=%0b ut=%0d want 1 27898", ut_valid, ut); end
    tick();
    checks++; if (ut_valid !== 1'b0) begin errors++; $display("FAIL ut_valid_width: got %0b want 0", ut_valid); end
    fb[0] = 8'h5D; fb[1] = 8'h23; fb[2] = 8'h00;
    send_frame(2'd3, 3);
    tick(); tick();
    checks++; if ({up_valid, up} !== {1'b1, 19'd23843}) begin errors++; $display("FAIL up_oss0: got v=%0b up=%0d want 1 23843", up_valid, up); end
    tick();
    checks++; if (up_valid !== 1'b0) begin errors++; $display("FAIL up_valid_width: got %0b want 0", up_valid); end
    fb[2] = 8'h80;
    send_frame(2'd3, 3);
    tick(); tick();
    checks++; if ({up_valid_3, up_3} !== {1'b1, 19'd190748}) begin errors++; $display("FAIL up_oss3: got v=%0b up=%0d want 1 190748", up_valid_3, up_3); end
    m_ut = 16'd27898; m_up0 = 19'd23843; m_up3 = 19'd190748;
  endtask

  task automatic test_abort();
    for (int i = 0; i < 10; i++) fb[i] = 8'(8'h10 + i);
    send_frame(2'd1, 10);
    m_calib_valid = 1'b0; m_calib_bad = 1'b0;
    frame_start = 1'b1; frame_type = 2'd2;
    tick();
    frame_start = 1'b0;
    checks++; if ({frame_error, calib_valid, busy} !== 3'b101)
      begin errors++; $display("FAIL abort_pulse: got err=%0b cv=%0b busy=%0b want 1 0 1", frame_error, calib_valid, busy); end
    send_byte(8'h12);
    checks++; if (frame_error !== 1'b0) begin errors++; $display("FAIL abort_err_width: got %0b want 0", frame_error); end
    send_byte(8'h34);
    tick(); tick();
    checks++; if ({ut_valid, ut, calib_valid} !== {1'b1, 16'h1234, 1'b0})
      begin errors++; $display("FAIL abort_temp: got v=%0b ut=%0h cv=%0b want 1 1234 0", ut_valid, ut, calib_valid); end
    m_ut = 16'h1234;
  endtask

  task automatic test_idle_byte();
    send_byte(8'hAA);
    checks++; if ({frame_error, busy} !== 2'b10) begin errors++; $display("FAIL idle_byte_err: got err=%0b busy=%0b want 1 0", frame_error, busy); end
    tick();
    checks++; if ({ut, up, chip_id, ut_valid, up_valid} !== {m_ut, m_up0, m_chip_id, 2'b00})
      begin errors++; $display("FAIL idle_byte_hold: got ut=%0h up=%0h id=%0h want %0h %0h %0h", ut, up, chip_id, m_ut, m_up0, m_chip_id); end
  endtask

  task automatic test_coincident();
    frame_start = 1'b1; frame_type = 2'd3; byte_valid = 1'b1; byte_in = 8'hA1;
    tick();
    frame_start = 1'b0; byte_valid = 1'b0;
    checks++; if (frame_error !== 1'b0) begin errors++; $display("FAIL coincident_err: got %0b want 0", frame_error); end
    send_byte(8'hB2); send_byte(8'hC3);
    tick(); tick();
    m_up0 = 19'((161 * 65536 + 178 * 256 + 195) / 256);
    m_up3 = 19'((161 * 65536 + 178 * 256 + 195) / 32);
    checks++; if ({up, up_3} !== {m_up0, m_up3}) begin errors++; $display("FAIL coincident_up: got %0d/%0d want %0d/%0d", up, up_3, m_up0, m_up3); end
  endtask

  task automatic test_back_to_back();
    fb[0] = 8'h0F; fb[1] = 8'hE1;
    send_frame(2'd2, 2);
    tick();
    send_byte(8'h99);
    checks++; if ({ut_valid, ut, frame_error} !== {1'b1, 16'h0FE1, 1'b1})
      begin errors++; $display("FAIL commit_byte: got v=%0b ut=%0h err=%0b want 1 0fe1 1", ut_valid, ut, frame_error); end
    fb[0] = 8'h77; fb[1] = 8'h66;
    send_frame(2'd2, 2);
    tick();
    fb[0] = 8'h44; fb[1] = 8'h33;
    send_frame(2'd2, 0);
    checks++; if ({ut_valid, ut, frame_error} !== {1'b0, 16'h0FE1, 1'b1})
      begin errors++; $display("FAIL commit_abort: got v=%0b ut=%0h err=%0b want 0 0fe1 1", ut_valid, ut, frame_error); end
    send_byte(fb[0]); send_byte(fb[1]);
    tick(); tick();
    checks++; if ({ut_valid, ut} !== {1'b1, 16'h4433}) begin errors++; $display("FAIL after_abort_ut: got v=%0b ut=%0h want 1 4433", ut_valid, ut); end
    m_ut = 16'h4433;
  endtask

  task automatic test_random();
    int t, n, v;
    logic [15:0] expv;
    for (int it = 0; it < 24; it++) begin
      t = $urandom_range(0, 3);
      n = (t == 0) ? 1 : (t == 1) ? 22 : (t == 2) ? 2 : 3;
      for (int i = 0; i < 24; i++) fb[i] = 8'($urandom_range(0, 255));
      if (t == 0 && $urandom_range(0, 1) == 0) fb[0] = 8'h55;
      if (t == 1) begin
        for (int i = 0; i < 11; i++) m_calib[i] = 16'($urandom_range(1, 65534));
        if ($urandom_range(0, 2) == 0) m_calib[$urandom_range(0, 10)] = ($urandom_range(0, 1) == 0) ? 16'h0000 : 16'hFFFF;
        calib_to_bytes();
      end
      send_frame(2'(t), n);
      tick(); tick();
      v = fb[0] * 65536 + fb[1] * 256 + fb[2];
      case (t)
        0: begin
          m_chip_id = fb[0]; m_id_valid = 1'b1; m_id_bad = (fb[0] != 8'h55);
          checks++; if ({chip_id, id_valid, id_bad} !== {m_chip_id, m_id_valid, m_id_bad})
            begin errors++; $display("FAIL rand_id[%0d]: got %0h %0b %0b want %0h %0b %0b", it, chip_id, id_valid, id_bad, m_chip_id, m_id_valid, m_id_bad); end
        end
        1: begin
          m_calib_valid = 1'b1; m_calib_bad = model_calib_bad();
          checks++; if ({calib_valid, calib_bad} !== {m_calib_valid, m_calib_bad})
            begin errors++; $display("FAIL rand_calib_flags[%0d]: got %0b %0b want 1 %0b", it, calib_valid, calib_bad, m_calib_bad); end
          for (int a = 0; a < 16; a++) begin
            calib_addr = 4'(a);
            @(negedge clk);
            expv = (a < 11) ? m_calib[a] : 16'h0000;
            checks++; if (calib_data !== expv) begin errors++; $display("FAIL rand_calib_read[%0d]: got %0h want %0h", a, calib_data, expv); end
          end
          tick();
        end
        2: begin
          m_ut = 16'(fb[0] * 256 + fb[1]);
          checks++; if ({ut_valid, ut} !== {1'b1, m_ut}) begin errors++; $display("FAIL rand_ut[%0d]: got %0b %0h want 1 %0h", it, ut_valid, ut, m_ut); end
        end
        default: begin
          m_up0 = 19'(v / 256); m_up3 = 19'(v / 32);
          checks++; if ({up_valid, up, up_3} !== {1'b1, m_up0, m_up3})
            begin errors++; $display("FAIL rand_up[%0d]: got %0b %0d %0d want 1 %0d %0d", it, up_valid, up, up_3, m_up0, m_up3); end
        end
      endcase
    end
  endtask

  task automatic test_reset_mid();
    load_datasheet_calib();
    calib_to_bytes();
    send_frame(2'd1, 22);
    tick(); tick();
    checks++; if (calib_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_calib: got %0b want 1", calib_valid); end
    fb[0] = 8'h5D;
    send_frame(2'd3, 1);
    reset = 1'b1;
    calib_addr = 4'd0;
    tick();
    checks++;
    if ({chip_id, id_valid, id_bad, calib_valid, calib_bad, ut, ut_valid, up, up_valid, frame_error, busy, calib_data} !== 76'd0)
      begin errors++; $display("FAIL reset_mid: got id=%0h cv=%0b ut=%0h up=%0h busy=%0b cd=%0h want all 0", chip_id, calib_valid, ut, up, busy, calib_data); end
    reset = 1'b0;
    model_clear();
    tick();
  endtask

  initial begin
    model_clear();
    test_reset();
    test_id();
    test_calib();
    test_temp_press();
    test_abort();
    test_idle_byte();
    test_coincident();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
